// File: rtl/buzzer_tone_gen.sv
// -----------------------------------------------------------------------------
// buzzer_tone_gen
//
// Purpose:
//   Last stage of the melody sequencer. Takes one note per valid/ready
//   handshake (3-bit note code plus a duration in clock cycles). It drives a
//   50%-duty square wave at that note's pitch onto the passive buzzer pin for
//   exactly the requested number of cycles. When a note ends normally, it
//   emits a single-cycle done pulse so the sequencer can issue the next note.
//
// Parameters:
//   CLK_HZ  input clock frequency in Hz; pitch half-periods are derived from it
//   DUR_W   width of note_dur and of the duration counter
//   HP_W    width of the half-period counter
//
// Ports:
//   clk         in   1      system clock (only clock)
//   rst_n       in   1      asynchronous active-low reset
//   note_valid  in   1      note_code / note_dur are valid
//   note_ready  out  1      a note can be accepted (IDLE and no stop)
//   note_code   in   3      0=C 1=D 2=E 3=F 4=G 5=A 6=B 7=rest
//   note_dur    in   DUR_W  note length in clock cycles
//   stop        in   1      synchronous abort of the current note
//   buzzer      out  1      registered square-wave drive
//   busy        out  1      registered, high while playing
//   done        out  1      registered, one-cycle pulse on normal completion
// -----------------------------------------------------------------------------
module buzzer_tone_gen #(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned DUR_W  = 24,
  parameter int unsigned HP_W   = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             note_valid,
  output logic             note_ready,
  input  logic [2:0]       note_code,
  input  logic [DUR_W-1:0] note_dur,
  input  logic             stop,
  output logic             buzzer,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0]       REST_CODE = 3'd7;
  localparam logic [HP_W-1:0]  HP_ONE    = HP_W'(1);
  localparam logic [DUR_W-1:0] DUR_ONE   = DUR_W'(1);

  // Nominal pitch of each note code, in Hz.
  function automatic int unsigned note_freq(input int unsigned k);
    case (k)
      0:       note_freq = 261;
      1:       note_freq = 294;
      2:       note_freq = 329;
      3:       note_freq = 349;
      4:       note_freq = 392;
      5:       note_freq = 440;
      6:       note_freq = 493;
      default: note_freq = 1;
    endcase
  endfunction

  // Half-period in clocks: floor(CLK_HZ / (2*f)), never below one cycle so
  // the toggle logic always has a reachable terminal count.
  function automatic logic [HP_W-1:0] half_of(input int unsigned f);
    logic [63:0] h;
    h = 64'(CLK_HZ) / (64'(f) * 64'd2);
    if (h == 64'd0) begin
      h = 64'd1;
    end
    half_of = h[HP_W-1:0];
  endfunction

  // The lowest pitch (C) has the longest half-period; it must fit HP_W.
  generate
    if ((64'(CLK_HZ) / 64'd522) >= (64'd1 << HP_W)) begin : g_hp_w_too_small
      $error("buzzer_tone_gen: HP_W too narrow for the C half-period at this CLK_HZ");
    end
  endgenerate

  // Constant half-period table, fixed at elaboration. The rest slot never
  // toggles, so its entry only needs to be a harmless non-zero value.
  logic [HP_W-1:0] half_tbl [8];

  genvar gi;
  generate
    for (gi = 0; gi < 7; gi++) begin : g_half_tbl
      localparam logic [HP_W-1:0] HALF = half_of(note_freq(gi));
      assign half_tbl[gi] = HALF;
    end
  endgenerate
  assign half_tbl[7] = HP_ONE;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } state_t;

  state_t           state_q;
  logic [DUR_W-1:0] dur_cnt_q;
  logic [HP_W-1:0]  hp_cnt_q;
  logic [HP_W-1:0]  half_q;
  logic             rest_q;
  logic             buzzer_q;
  logic             busy_q;
  logic             done_q;

  logic             accept_d;
  logic             hp_wrap_d;
  logic             last_cycle_d;

  // stop masks readiness, which gives stop priority over note_valid in IDLE.
  assign note_ready   = (state_q == ST_IDLE) && !stop;
  assign accept_d     = note_valid && note_ready;
  assign hp_wrap_d    = (hp_cnt_q == (half_q - HP_ONE));
  assign last_cycle_d = (dur_cnt_q == DUR_ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      dur_cnt_q <= '0;
      hp_cnt_q  <= '0;
      half_q    <= HP_ONE;
      rest_q    <= 1'b0;
      buzzer_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      // done is a pulse: it is only raised for the single edge that ends a note.
      done_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (accept_d) begin
            dur_cnt_q <= note_dur;
            hp_cnt_q  <= '0;
            half_q    <= half_tbl[note_code];
            rest_q    <= (note_code == REST_CODE);
            if (note_dur == '0) begin
              // Zero-length note: nothing to play, just acknowledge it.
              done_q <= 1'b1;
            end else begin
              state_q  <= ST_PLAY;
              busy_q   <= 1'b1;
              buzzer_q <= (note_code != REST_CODE);
            end
          end
        end

        ST_PLAY: begin
          if (stop) begin
            // Abort: silent return to IDLE with no completion pulse.
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            buzzer_q  <= 1'b0;
            dur_cnt_q <= '0;
            hp_cnt_q  <= '0;
          end else if (last_cycle_d) begin
            // Final PLAY cycle; any unfinished half-period is simply cut off.
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            buzzer_q  <= 1'b0;
            done_q    <= 1'b1;
            dur_cnt_q <= '0;
            hp_cnt_q  <= '0;
          end else begin
            dur_cnt_q <= dur_cnt_q - DUR_ONE;
            if (hp_wrap_d) begin
              // Counter spans 0..HALF-1, so each level lasts exactly HALF cycles.
              hp_cnt_q <= '0;
              if (!rest_q) begin
                buzzer_q <= ~buzzer_q;
              end
            end else begin
              hp_cnt_q <= hp_cnt_q + HP_ONE;
            end
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign buzzer = buzzer_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_buzzer_tone_gen.sv
// -----------------------------------------------------------------------------
// tb_buzzer_tone_gen
//
// Purpose:
//   Self-checking bench for buzzer_tone_gen with CLK_HZ=88_000, which gives
//   half-periods A=100, C=168, B=89 clocks. Single notes come from a vector
//   table. Back-to-back, stop and mid-note reset are hand-written sequences.
//   Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_buzzer_tone_gen;

  localparam int unsigned DUR_W = 24;
  localparam int unsigned HP_W  = 24;

  logic             clk;
  logic             rst_n;
  logic             note_valid;
  logic             note_ready;
  logic [2:0]       note_code;
  logic [DUR_W-1:0] note_dur;
  logic             stop;
  logic             buzzer;
  logic             busy;
  logic             done;

  int n_checks;
  int n_errors;

  buzzer_tone_gen #(
    .CLK_HZ (88_000),
    .DUR_W  (DUR_W),
    .HP_W   (HP_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .note_valid (note_valid),
    .note_ready (note_ready),
    .note_code  (note_code),
    .note_dur   (note_dur),
    .stop       (stop),
    .buzzer     (buzzer),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0] code;
    int         dur;
    int         exp_busy;
    int         exp_high;
    int         exp_runs;
    int         exp_first;
    int         exp_last;
  } vec_t;

  vec_t vecs [5];

  // Present one note and observe dur+4 cycles after the accepting edge.
  // Cycle 1 is the first cycle after acceptance.
  task automatic play_and_measure(input logic [2:0] code, input int dur,
                                  output int busy_cnt, output int high_cnt,
                                  output int runs, output int first_run,
                                  output int last_run, output int done_cnt,
                                  output int done_idx);
    int guard;
    int cur;
    bit prev;
    busy_cnt = 0; high_cnt = 0; runs = 0; first_run = 0; last_run = 0;
    done_cnt = 0; done_idx = -1; cur = 0; prev = 1'b0;
    guard = 0;
    while (note_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("ready_before_note", {31'd0, note_ready}, 32'd1);
    note_code  = code;
    note_dur   = DUR_W'(dur);
    note_valid = 1'b1;
    @(negedge clk);
    note_valid = 1'b0;
    for (int i = 1; i <= dur + 4; i++) begin
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        done_cnt++;
        done_idx = i;
      end
      if (buzzer === 1'b1) begin
        high_cnt++;
        if (!prev) begin
          runs++;
          cur = 0;
        end
        cur++;
      end else if (prev) begin
        if (runs == 1) first_run = cur;
        last_run = cur;
      end
      prev = (buzzer === 1'b1);
      @(negedge clk);
    end
  endtask

  initial begin
    int b, h, r, fr, lr, dc, di;
    int gap, b2b_busy, b2b_done, stop_busy, late_busy;

    n_checks = 0;
    n_errors = 0;

    //             code  dur   busy  high runs first last
    vecs[0] = '{3'd5, 1000, 1000, 500, 5, 100, 100};  // A: 5 full periods
    vecs[1] = '{3'd0,  500,  500, 332, 2, 168, 164};  // C: last half truncated
    vecs[2] = '{3'd7,  300,  300,   0, 0,   0,   0};  // rest: silent
    vecs[3] = '{3'd5,    0,    0,   0, 0,   0,   0};  // zero duration
    vecs[4] = '{3'd6,  200,  200, 111, 2,  89,  22};  // B: 89 high, 89 low, 22 high

    rst_n = 1'b0; note_valid = 1'b0; note_code = 3'd0; note_dur = '0; stop = 1'b0;

    // Reset state
    @(negedge clk);
    check("reset_buzzer", {31'd0, buzzer}, 32'd0);
    check("reset_busy",   {31'd0, busy},   32'd0);
    check("reset_done",   {31'd0, done},   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", {31'd0, note_ready}, 32'd1);
    stop = 1'b1;
    #1;
    check("ready_masked_by_stop", {31'd0, note_ready}, 32'd0);
    stop = 1'b0;
    @(negedge clk);

    // Table-driven single notes
    for (int v = 0; v < 5; v++) begin
      play_and_measure(vecs[v].code, vecs[v].dur, b, h, r, fr, lr, dc, di);
      $display("note code=%0d dur=%0d busy=%0d high=%0d runs=%0d first=%0d last=%0d done=%0d@%0d",
               vecs[v].code, vecs[v].dur, b, h, r, fr, lr, dc, di);
      check($sformatf("v%0d_busy_cycles", v), b,  vecs[v].exp_busy);
      check($sformatf("v%0d_high_cycles", v), h,  vecs[v].exp_high);
      check($sformatf("v%0d_high_runs", v),   r,  vecs[v].exp_runs);
      check($sformatf("v%0d_first_run", v),   fr, vecs[v].exp_first);
      check($sformatf("v%0d_last_run", v),    lr, vecs[v].exp_last);
      check($sformatf("v%0d_done_count", v),  dc, 1);
      check($sformatf("v%0d_done_cycle", v),  di, vecs[v].dur + 1);
      check($sformatf("v%0d_ready_after", v), {31'd0, note_ready}, 32'd1);
    end

    // Back-to-back: B 200 then A 200 with valid held through the done cycle.
    note_code = 3'd6; note_dur = DUR_W'(200); note_valid = 1'b1;
    @(negedge clk);
    note_code = 3'd5; note_dur = DUR_W'(200);
    gap = 0; b2b_busy = 0; b2b_done = 0;
    for (int i = 1; i <= 405; i++) begin
      if (busy === 1'b1) b2b_busy++;
      else if (i <= 401) gap++;
      if (done === 1'b1) b2b_done++;
      if (i == 201) begin
        check("b2b_done_in_gap",  {31'd0, done},       32'd1);
        check("b2b_ready_in_gap", {31'd0, note_ready}, 32'd1);
        check("b2b_buzzer_gap",   {31'd0, buzzer},     32'd0);
      end
      if (i == 202) begin
        check("b2b_second_busy",   {31'd0, busy},   32'd1);
        check("b2b_second_buzzer", {31'd0, buzzer}, 32'd1);
        note_valid = 1'b0;
      end
      @(negedge clk);
    end
    $display("b2b B200+A200 busy=%0d gap=%0d done=%0d", b2b_busy, gap, b2b_done);
    check("b2b_busy_total", b2b_busy, 400);
    check("b2b_gap",        gap,      1);
    check("b2b_done_count", b2b_done, 2);

    // stop at cycle 250 of A dur=1000; a valid note held during stop is refused.
    note_code = 3'd5; note_dur = DUR_W'(1000); note_valid = 1'b1;
    @(negedge clk);
    note_valid = 1'b0;
    stop_busy = 0; late_busy = 0; dc = 0;
    for (int i = 1; i <= 260; i++) begin
      if (busy === 1'b1) begin
        stop_busy++;
        if (i > 250) late_busy++;
      end
      if (done === 1'b1) dc++;
      if (i == 250) begin
        check("stop_buzzer_before", {31'd0, buzzer}, 32'd1);
        stop = 1'b1;
        note_valid = 1'b1; note_dur = DUR_W'(10);
      end
      if (i == 251) begin
        check("stop_buzzer_after", {31'd0, buzzer},     32'd0);
        check("stop_busy_after",   {31'd0, busy},       32'd0);
        check("stop_ready_masked", {31'd0, note_ready}, 32'd0);
      end
      @(negedge clk);
    end
    note_valid = 1'b0;
    stop = 1'b0;
    $display("stop A1000@250 busy=%0d late_busy=%0d done=%0d", stop_busy, late_busy, dc);
    check("stop_busy_cycles", stop_busy, 250);
    check("stop_no_accept",   late_busy, 0);
    check("stop_no_done",     dc,        0);
    @(negedge clk);

    // Asynchronous reset pulse in the middle of a high half-period.
    note_code = 3'd5; note_dur = DUR_W'(1000); note_valid = 1'b1;
    @(negedge clk);
    note_valid = 1'b0;
    for (int i = 1; i < 50; i++) @(negedge clk);
    check("rst_buzzer_before", {31'd0, buzzer}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_buzzer_immediate", {31'd0, buzzer}, 32'd0);
    check("rst_busy_immediate",   {31'd0, busy},   32'd0);
    check("rst_done_immediate",   {31'd0, done},   32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dc = 0; b = 0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) dc++;
      if (busy === 1'b1) b++;
      @(negedge clk);
    end
    $display("reset mid-note busy=%0d done=%0d ready=%0d", b, dc, note_ready);
    check("rst_no_done",     dc, 0);
    check("rst_stays_idle",  b,  0);
    check("rst_ready_after", {31'd0, note_ready}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
